// File: rtl/mips_pkg.sv
// Shared constants and helpers for the instruction fetch slice.
// Everything here is width-agnostic enough to serve the fetch and decode stages.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam int          WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Source of the PC for the next edge, in decreasing priority order.
  typedef enum logic [1:0] {
    PC_BRANCH = 2'd0,
    PC_JUMP   = 2'd1,
    PC_HOLD   = 2'd2,
    PC_SEQ    = 2'd3
  } pc_sel_e;

  function automatic logic is_misaligned(input logic [1:0] byte_offset);
    return byte_offset != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_select.sv
// Next-PC selection: branch > jump > stall > sequential, with forced word
// alignment of redirect targets and detection of misaligned targets.
module pc_select
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  redirect,
  output logic                  misalign
);

  pc_sel_e               sel;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] target_aligned;

  // Branch wins over jump because it resolves for the older instruction.
  always_comb begin
    sel = PC_SEQ;
    if (branch_taken) begin
      sel = PC_BRANCH;
    end else if (jump) begin
      sel = PC_JUMP;
    end else if (stall) begin
      sel = PC_HOLD;
    end
  end

  always_comb begin
    pc_plus4       = pc + ADDR_WIDTH'(WORD_BYTES);
    target         = (sel == PC_BRANCH) ? branch_target : jump_target;
    target_aligned = {target[ADDR_WIDTH-1:2], 2'b00};
    redirect       = (sel == PC_BRANCH) || (sel == PC_JUMP);
    misalign       = redirect && is_misaligned(target[1:0]);
  end

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      PC_BRANCH: next_pc = target_aligned;
      PC_JUMP:   next_pc = target_aligned;
      PC_HOLD:   next_pc = pc;
      PC_SEQ:    next_pc = pc_plus4;
      default:   next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction
// memory and fills the IF/ID pipeline register, honouring stall/flush/redirects.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_instr,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic [ADDR_WIDTH-1:0] if_id_pc,
  output logic [ADDR_WIDTH-1:0] if_id_pc_plus4,
  output logic [31:0]           if_id_instr,
  output logic                  if_id_valid,
  output logic                  misalign_err,
  output logic [31:0]           fetch_count
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic                  redirect;
  logic                  misalign;

  logic [ADDR_WIDTH-1:0] if_id_pc_q,       if_id_pc_d;
  logic [ADDR_WIDTH-1:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic [31:0]           if_id_instr_q,    if_id_instr_d;
  logic                  if_id_valid_q,    if_id_valid_d;
  logic                  misalign_q;
  logic [31:0]           fetch_count_q,    fetch_count_d;

  pc_select #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pc_select (
    .pc            (pc_q),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .next_pc       (pc_d),
    .pc_plus4      (pc_plus4),
    .redirect      (redirect),
    .misalign      (misalign)
  );

  // A redirect squashes whatever was fetched this cycle, so it bubbles like a flush.
  always_comb begin
    if_id_pc_d       = if_id_pc_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    if_id_instr_d    = if_id_instr_q;
    if_id_valid_d    = if_id_valid_q;
    fetch_count_d    = fetch_count_q;
    if (redirect || flush) begin
      if_id_pc_d       = '0;
      if_id_pc_plus4_d = '0;
      if_id_instr_d    = NOP_INSTR;
      if_id_valid_d    = 1'b0;
    end else if (!stall) begin
      if_id_pc_d       = pc_q;
      if_id_pc_plus4_d = pc_plus4;
      if_id_instr_d    = imem_instr;
      if_id_valid_d    = 1'b1;
      fetch_count_d    = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q             <= RESET_PC;
      if_id_pc_q       <= '0;
      if_id_pc_plus4_q <= '0;
      if_id_instr_q    <= NOP_INSTR;
      if_id_valid_q    <= 1'b0;
      misalign_q       <= 1'b0;
      fetch_count_q    <= '0;
    end else begin
      pc_q             <= pc_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_valid_q    <= if_id_valid_d;
      misalign_q       <= misalign;
      fetch_count_q    <= fetch_count_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc_plus4 = if_id_pc_plus4_q;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_valid    = if_id_valid_q;
  assign misalign_err   = misalign_q;
  assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized control traffic
// compared against a behavioural fetch-stage model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_instr;
  logic        stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr, fetch_count;
  logic        if_id_valid, misalign_err;

  logic        w_reset;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4, w_ifid_instr, w_count;
  logic        w_valid, w_mis;
  logic        w_zero = 1'b0;
  logic [31:0] w_zero32 = 32'h0;

  logic [31:0] mem [0:255];
  assign imem_instr = mem[imem_addr[9:2]];
  assign w_instr    = mem[w_addr[9:2]];

  int checks = 0;
  int errors = 0;

  // Behavioural model of the fetch stage
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;
  logic        m_valid, m_mis;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .stall(stall), .flush(flush), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(w_reset), .imem_addr(w_addr), .imem_instr(w_instr),
    .stall(w_zero), .flush(w_zero), .branch_taken(w_zero),
    .branch_target(w_zero32), .jump(w_zero), .jump_target(w_zero32),
    .if_id_pc(w_pc), .if_id_pc_plus4(w_pc4), .if_id_instr(w_ifid_instr),
    .if_id_valid(w_valid), .misalign_err(w_mis), .fetch_count(w_count)
  );

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 0; m_ipc4 = 0; m_instr = 0; m_valid = 0; m_cnt = 0; m_mis = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    {stall, flush, branch_taken, jump} = 4'b0;
    branch_target = 0; jump_target = 0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Drive one cycle of controls, advance the model, and wait past the edge.
  task automatic drive_cycle(input logic br, input logic [31:0] bt, input logic j,
                             input logic [31:0] jt, input logic st, input logic fl);
    logic [31:0] tgt;
    logic        redir;
    branch_taken = br; branch_target = bt; jump = j; jump_target = jt;
    stall = st; flush = fl;
    tgt   = br ? bt : jt;
    redir = br | j;
    if (redir || fl) begin
      m_ipc = 0; m_ipc4 = 0; m_instr = 0; m_valid = 0;
    end else if (!st) begin
      m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = mem[m_pc[9:2]]; m_valid = 1;
      m_cnt = m_cnt + 1;
    end
    m_mis = redir && (tgt % 4 != 0);
    m_pc  = redir ? (tgt / 4) * 4 : (st ? m_pc : m_pc + 4);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
        if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h0 || fetch_count !== 32'h0 ||
        misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got addr=%h valid=%b instr=%h pc=%h pc4=%h cnt=%0d mis=%b expected all zero",
               imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count, misalign_err);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(0, 0, 0, 0, 0, 0);
      checks++;
      if (if_id_pc !== 32'(i * 4) || if_id_instr !== mem[i] || if_id_valid !== 1'b1 ||
          if_id_pc_plus4 !== 32'(i * 4 + 4)) begin
        errors++;
        $display("FAIL seq_fetch[%0d]: got pc=%h pc4=%h instr=%h valid=%b expected pc=%h pc4=%h instr=%h valid=1",
                 i, if_id_pc, if_id_pc_plus4, if_id_instr, if_id_valid, i * 4, i * 4 + 4, mem[i]);
      end
    end
    checks++;
    if (fetch_count !== 32'd8) begin
      errors++;
      $display("FAIL seq_count: got %0d expected 8", fetch_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive_cycle(0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, 0, 0, 1, 0);
      checks++;
      if (imem_addr !== 32'h8 || if_id_pc !== 32'h4 || fetch_count !== 32'd2 || if_id_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got addr=%h ifid_pc=%h cnt=%0d valid=%b expected addr=8 ifid_pc=4 cnt=2 valid=1",
                 i, imem_addr, if_id_pc, fetch_count, if_id_valid);
      end
    end
    drive_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (if_id_pc !== 32'h8 || imem_addr !== 32'hC) begin
      errors++;
      $display("FAIL stall_release: got ifid_pc=%h addr=%h expected ifid_pc=8 addr=c", if_id_pc, imem_addr);
    end
  endtask

  task automatic test_branch();
    do_reset();
    repeat (3) drive_cycle(0, 0, 0, 0, 0, 0);
    drive_cycle(1, 32'h40, 0, 0, 0, 0);
    checks++;
    if (imem_addr !== 32'h40 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
      errors++;
      $display("FAIL branch_bubble: got addr=%h valid=%b instr=%h expected addr=40 valid=0 instr=0",
               imem_addr, if_id_valid, if_id_instr);
    end
    drive_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (if_id_pc !== 32'h40 || if_id_valid !== 1'b1 || if_id_instr !== mem[16]) begin
      errors++;
      $display("FAIL branch_target_fetch: got pc=%h valid=%b instr=%h expected pc=40 valid=1 instr=%h",
               if_id_pc, if_id_valid, if_id_instr, mem[16]);
    end
  endtask

  task automatic test_all_controls();
    drive_cycle(1, 32'h40, 1, 32'h80, 1, 1);
    checks++;
    if (imem_addr !== 32'h40 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
        if_id_pc !== 32'h0 || misalign_err !== 1'b0 || fetch_count !== m_cnt) begin
      errors++;
      $display("FAIL all_controls: got addr=%h valid=%b instr=%h pc=%h mis=%b cnt=%0d expected addr=40 valid=0 instr=0 pc=0 mis=0 cnt=%0d",
               imem_addr, if_id_valid, if_id_instr, if_id_pc, misalign_err, fetch_count, m_cnt);
    end
  endtask

  task automatic test_misalign();
    drive_cycle(0, 0, 1, 32'h102, 0, 0);
    checks++;
    if (imem_addr !== 32'h100 || misalign_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_pulse: got addr=%h mis=%b expected addr=100 mis=1", imem_addr, misalign_err);
    end
    drive_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (misalign_err !== 1'b0 || if_id_pc !== 32'h100) begin
      errors++;
      $display("FAIL misalign_clear: got mis=%b pc=%h expected mis=0 pc=100", misalign_err, if_id_pc);
    end
  endtask

  task automatic test_random();
    logic        br, j, st, fl;
    logic [31:0] bt, jt;
    for (int n = 0; n < 300; n++) begin
      br = ($urandom_range(0, 9) == 0);
      j  = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 7) == 0);
      bt = $urandom_range(0, 1023);
      jt = $urandom_range(0, 1023);
      drive_cycle(br, bt, j, jt, st, fl);
      checks++;
      if (imem_addr !== m_pc || if_id_valid !== m_valid || if_id_pc !== m_ipc ||
          if_id_pc_plus4 !== m_ipc4 || if_id_instr !== m_instr ||
          fetch_count !== m_cnt || misalign_err !== m_mis) begin
        errors++;
        $display("FAIL random[%0d]: got addr=%h v=%b pc=%h pc4=%h instr=%h cnt=%0d mis=%b expected addr=%h v=%b pc=%h pc4=%h instr=%h cnt=%0d mis=%b",
                 n, imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, fetch_count, misalign_err,
                 m_pc, m_valid, m_ipc, m_ipc4, m_instr, m_cnt, m_mis);
      end
    end
  endtask

  task automatic test_wrap_and_async_reset();
    @(negedge clk);
    w_reset = 1'b0;
    checks++;
    if (w_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_first_addr: got %h expected fffffffc", w_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (w_addr !== 32'h0 || w_pc !== 32'hFFFF_FFFC || w_pc4 !== 32'h0 || w_valid !== 1'b1 ||
        w_ifid_instr !== mem[255]) begin
      errors++;
      $display("FAIL wrap_second_addr: got addr=%h pc=%h pc4=%h valid=%b instr=%h expected addr=0 pc=fffffffc pc4=0 valid=1 instr=%h",
               w_addr, w_pc, w_pc4, w_valid, w_ifid_instr, mem[255]);
    end
    @(posedge clk); #1;
    checks++;
    if (w_addr !== 32'h4 || w_pc !== 32'h0 || w_pc4 !== 32'h4 || w_count !== 32'd2) begin
      errors++;
      $display("FAIL wrap_continue: got addr=%h pc=%h pc4=%h cnt=%0d expected addr=4 pc=0 pc4=4 cnt=2",
               w_addr, w_pc, w_pc4, w_count);
    end
    #2;
    w_reset = 1'b1;
    #1;
    checks++;
    if (w_addr !== 32'hFFFF_FFFC || w_valid !== 1'b0 || w_count !== 32'd0 || w_mis !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got addr=%h valid=%b cnt=%0d mis=%b expected addr=fffffffc valid=0 cnt=0 mis=0",
               w_addr, w_valid, w_count, w_mis);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    w_reset = 1'b1;
    {stall, flush, branch_taken, jump} = 4'b0;
    branch_target = 0; jump_target = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_all_controls();
    test_misalign();
    test_random();
    test_wrap_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
